enemy_sprite_anim_addr: RTL and testbench

//  Upstream address/animation stage for an enemy running sprite.

---
 rtl/enemy_sprite_anim_addr.sv | 140 ++++++++++++++
 tb/tb_enemy_sprite_anim_addr.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_sprite_anim_addr.sv
// Address/animation stage for the enemy running sprite: frame-tick FSM,
// per-frame position latch and a 2-cycle scan-to-ROM-address pipeline.
module enemy_sprite_anim_addr #(
   parameter int unsigned SPR_W      = 40,
   parameter int unsigned SPR_H      = 66,
   parameter int unsigned NUM_FRAMES = 4,
   parameter int unsigned FRAME_HOLD = 6,
   parameter int unsigned ADDR_W     = 14,
   localparam int unsigned FI_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              vs,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic              running,
   input  logic              facing_left,
   output logic [ADDR_W-1:0] rom_address,
   output logic              in_sprite,
   output logic              blank_d,
   output logic [FI_W-1:0]   frame_idx
);

   localparam int unsigned HC_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
   localparam int unsigned AW1  = ADDR_W + 1;
   localparam logic [10:0]    SPR_W_C  = 11'(SPR_W);
   localparam logic [10:0]    SPR_H_C  = 11'(SPR_H);
   localparam logic [AW1-1:0] FRAME_SZ = AW1'(SPR_W * SPR_H);
   localparam logic [AW1-1:0] ROW_SZ   = AW1'(SPR_W);

   typedef enum logic {IDLE, RUN} state_e;

   state_e            state_q, state_d;
   logic [HC_W-1:0]   hold_q, hold_d;
   logic [FI_W-1:0]   frame_q, frame_d;
   logic              vs_q;
   logic              tick;
   logic [9:0]        pos_x_q, pos_y_q;
   logic              facing_q;

   logic [10:0]       dx_q, dy_q, dx_d, dy_d;
   logic              blank_s1_q;

   logic              in_win;
   logic [10:0]       sx;
   logic [AW1-1:0]    addr_full;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              in_sprite_q, blank_d_q;

   assign tick = vs_q & ~vs;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_q     <= 1'b1;
         state_q  <= IDLE;
         hold_q   <= '0;
         frame_q  <= '0;
         pos_x_q  <= '0;
         pos_y_q  <= '0;
         facing_q <= 1'b0;
      end else begin
         vs_q    <= vs;
         state_q <= state_d;
         hold_q  <= hold_d;
         frame_q <= frame_d;
         // Position/facing only move at the frame tick so a frame never tears.
         if (tick) begin
            pos_x_q  <= pos_x;
            pos_y_q  <= pos_y;
            facing_q <= facing_left;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      frame_d = frame_q;
      if (tick) begin
         unique case (state_q)
            IDLE: begin
               hold_d  = '0;
               frame_d = '0;
               if (running) state_d = RUN;
            end
            RUN: begin
               if (!running) begin
                  state_d = IDLE;
                  hold_d  = '0;
                  frame_d = '0;
               end else if (hold_q == HC_W'(FRAME_HOLD - 1)) begin
                  hold_d  = '0;
                  frame_d = (frame_q == FI_W'(NUM_FRAMES - 1)) ? '0 : frame_q + FI_W'(1);
               end else begin
                  hold_d = hold_q + HC_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Offsets carry a sign bit so positions left of/above the sprite never alias in.
   assign dx_d = {1'b0, DrawX} - {1'b0, pos_x_q};
   assign dy_d = {1'b0, DrawY} - {1'b0, pos_y_q};

   always_comb begin
      in_win = !dx_q[10] && (dx_q < SPR_W_C) && !dy_q[10] && (dy_q < SPR_H_C) && blank_s1_q;
      sx     = facing_q ? (SPR_W_C - 11'd1 - dx_q) : dx_q;
      addr_full = (AW1'(frame_q) * FRAME_SZ) + (AW1'(dy_q) * ROW_SZ) + AW1'(sx);
      rom_addr_d = in_win ? addr_full[ADDR_W-1:0] : '0;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         dx_q        <= '0;
         dy_q        <= '0;
         blank_s1_q  <= 1'b0;
         rom_addr_q  <= '0;
         in_sprite_q <= 1'b0;
         blank_d_q   <= 1'b0;
      end else begin
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         blank_s1_q  <= blank;
         rom_addr_q  <= rom_addr_d;
         in_sprite_q <= in_win;
         blank_d_q   <= blank_s1_q;
      end
   end

   assign rom_address = rom_addr_q;
   assign in_sprite   = in_sprite_q;
   assign blank_d     = blank_d_q;
   assign frame_idx   = frame_q;

endmodule

// File: tb/tb_enemy_sprite_anim_addr.sv
// Scoreboard bench for enemy_sprite_anim_addr: directed vectors plus random
// sprite placements checked against an arithmetic reference model.
module tb_enemy_sprite_anim_addr;

   localparam int SPR_W = 40;
   localparam int SPR_H = 66;
   localparam int NUM_FRAMES = 4;
   localparam int FRAME_HOLD = 6;
   localparam int ADDR_W = 14;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic [9:0]  DrawX, DrawY, pos_x, pos_y;
   logic        blank, vs, running, facing_left;
   logic [13:0] rom_address;
   logic        in_sprite, blank_d;
   logic [1:0]  frame_idx;

   always #5 vga_clk = ~vga_clk;

   enemy_sprite_anim_addr #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES),
      .FRAME_HOLD(FRAME_HOLD), .ADDR_W(ADDR_W)
   ) dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .vs(vs), .pos_x(pos_x), .pos_y(pos_y), .running(running),
      .facing_left(facing_left), .rom_address(rom_address), .in_sprite(in_sprite),
      .blank_d(blank_d), .frame_idx(frame_idx)
   );

   typedef struct {bit in_s; int addr; bit blk; int x; int y;} exp_t;
   exp_t exp_q[$];
   int total = 0;
   int bad = 0;
   bit vld0 = 1'b0;
   bit vld1, vld2;

   // reference model state
   int m_px, m_py, m_run_k;
   bit m_face;

   function automatic int m_frame();
      return (m_run_k < 0) ? 0 : (m_run_k / FRAME_HOLD) % NUM_FRAMES;
   endfunction

   function automatic void m_reset();
      m_px = 0; m_py = 0; m_face = 0; m_run_k = -1;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   always @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         vld1 <= 1'b0;
         vld2 <= 1'b0;
      end else begin
         vld1 <= vld0;
         vld2 <= vld1;
      end
   end

   // monitor: pops one expectation per presented pixel
   always @(negedge vga_clk) begin
      if (reset_n && vld2) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_underflow actual=empty required=entry");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (in_sprite !== e.in_s || rom_address !== 14'(e.addr) || blank_d !== e.blk) begin
               bad++;
               $display("FAIL pixel(%0d,%0d) actual in=%0b addr=%0d blank_d=%0b required in=%0b addr=%0d blank_d=%0b",
                        e.x, e.y, in_sprite, rom_address, blank_d, e.in_s, e.addr, e.blk);
            end
         end
      end
   end

   task automatic drive(int x, int y, bit b);
      @(negedge vga_clk);
      DrawX = 10'(x); DrawY = 10'(y); blank = b; vld0 = 1'b1;
   endtask

   task automatic pix(int x, int y, bit b);
      exp_t e;
      int dx, dy, sx;
      drive(x, y, b);
      dx = x - m_px;
      dy = y - m_py;
      e.in_s = b && dx >= 0 && dx < SPR_W && dy >= 0 && dy < SPR_H;
      sx = m_face ? (SPR_W - 1 - dx) : dx;
      e.addr = e.in_s ? (m_frame() * SPR_W * SPR_H + dy * SPR_W + sx) % (1 << ADDR_W) : 0;
      e.blk = b; e.x = x; e.y = y;
      exp_q.push_back(e);
   endtask

   task automatic pix_c(int x, int y, bit b, bit ein, int eaddr);
      exp_t e;
      drive(x, y, b);
      e.in_s = ein; e.addr = eaddr; e.blk = b; e.x = x; e.y = y;
      exp_q.push_back(e);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge vga_clk);
         vld0 = 1'b0; blank = 1'b0;
      end
   endtask

   task automatic tick_vs(bit run);
      idle(3);
      @(negedge vga_clk);
      vs = 1'b0; running = run;
      m_px = pos_x; m_py = pos_y; m_face = facing_left;
      if (run) m_run_k = (m_run_k < 0) ? 0 : m_run_k + 1;
      else m_run_k = -1;
      @(negedge vga_clk);
      vs = 1'b1;
      chk("frame_idx_after_tick", 32'(frame_idx), 32'(m_frame()));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int x, y;
      reset_n = 1'b0; vs = 1'b1; blank = 1'b0; running = 1'b0; facing_left = 1'b0;
      pos_x = '0; pos_y = '0; DrawX = '0; DrawY = '0;
      m_reset();
      repeat (3) @(negedge vga_clk);
      chk("reset_outputs", {in_sprite, blank_d, rom_address, frame_idx}, 32'd0);
      reset_n = 1'b1;
      @(negedge vga_clk);
      chk("frame_idx_after_release", 32'(frame_idx), 32'd0);

      // basic addressing
      pos_x = 10'd100; pos_y = 10'd50; facing_left = 1'b0;
      tick_vs(1'b0);
      pix_c(100, 50, 1, 1, 0);
      pix_c(139, 115, 1, 1, 2639);
      pix_c(140, 50, 1, 0, 0);
      pix(99, 50, 1); pix(100, 49, 1); pix(120, 116, 1);

      // mirroring
      facing_left = 1'b1;
      tick_vs(1'b0);
      pix_c(100, 50, 1, 1, 39);
      pix_c(139, 50, 1, 1, 0);
      pix(120, 80, 1);

      // animation stepping
      facing_left = 1'b0;
      for (int i = 1; i <= 25; i++) begin
         tick_vs(1'b1);
         if (i == 13) pix_c(100, 50, 1, 1, 5280);
      end
      chk("frame_after_25_ticks", 32'(frame_idx), 32'd0);

      // running dropped on the tick, and mid-frame position change
      repeat (6) tick_vs(1'b1);
      chk("frame_before_drop", 32'(frame_idx), 32'd1);
      tick_vs(1'b0);
      chk("frame_on_drop_tick", 32'(frame_idx), 32'd0);
      pos_x = 10'd300;
      pix_c(100, 50, 1, 1, 0);
      pix_c(300, 50, 1, 0, 0);
      tick_vs(1'b0);
      pix_c(300, 50, 1, 1, 0);
      pix_c(100, 50, 1, 0, 0);

      // right-edge clipping and blanking
      pos_x = 10'd620; pos_y = 10'd100;
      tick_vs(1'b0);
      for (int i = 0; i < 640; i++) pix(i, 100, 1);
      pix_c(0, 100, 1, 0, 0);
      pix_c(19, 100, 1, 0, 0);
      pix_c(639, 100, 1, 1, 19);
      pix_c(620, 165, 1, 1, 2600);
      pix_c(625, 110, 0, 0, 0);

      // offscreen position
      pos_x = 10'd700;
      tick_vs(1'b0);
      for (int i = 0; i < 640; i += 7) pix_c(i, 100 + (i % 60), 1, 0, 0);

      // randomized placements
      for (int it = 0; it < 40; it++) begin
         pos_x = 10'($urandom_range(0, 700));
         pos_y = 10'($urandom_range(0, 479));
         facing_left = 1'($urandom);
         tick_vs(1'($urandom));
         repeat (30) begin
            if (pos_x > 639) x = $urandom_range(0, 639);
            else x = int'(pos_x) + $urandom_range(0, 50) - 5;
            y = int'(pos_y) + $urandom_range(0, 76) - 5;
            if (x < 0) x = 0;
            if (x > 639) x = 639;
            if (y < 0) y = 0;
            if (y > 479) y = 479;
            pix(x, y, ($urandom % 4) != 0);
         end
      end

      // reset asserted mid-line while pixels are in flight
      pos_x = 10'd100; pos_y = 10'd50; facing_left = 1'b0;
      repeat (8) tick_vs(1'b1);
      pix(110, 60, 1); pix(111, 60, 1);
      @(posedge vga_clk);
      #3;
      vld0 = 1'b0;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midline_reset_outputs", {in_sprite, blank_d, rom_address, frame_idx}, 32'd0);
      m_reset();
      running = 1'b0;
      repeat (2) @(negedge vga_clk);
      reset_n = 1'b1;
      @(negedge vga_clk);
      chk("frame_idx_after_midline_reset", 32'(frame_idx), 32'd0);
      pix_c(5, 5, 1, 1, 5 * SPR_W + 5);
      pix(110, 60, 1);
      idle(4);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
